// File: rtl/ld_str_mem_responder_if.sv
// Request/response bundle between the load/store address stage and the memory responder.
// The master side issues requests and consumes responses; the slave side is the responder.
interface ld_str_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int RD_W   = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_w_en;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [RD_W-1:0]   req_rd_addr;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [TAG_W-1:0]  resp_tag;
  logic [RD_W-1:0]   resp_rd_addr;
  logic              resp_is_store;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_w_en, req_size, req_signed, req_wdata, req_tag, req_rd_addr,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_tag, resp_rd_addr, resp_is_store, resp_err,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_addr, req_w_en, req_size, req_signed, req_wdata, req_tag, req_rd_addr,
    output req_ready,
    output resp_valid, resp_rdata, resp_tag, resp_rd_addr, resp_is_store, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/ld_str_mem_responder.sv
// Single-outstanding load/store responder over a word-organised data RAM with
// programmable wait states, byte-lane stores and sign/zero-extended loads.
module ld_str_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter int TAG_W       = 4,
  parameter int RD_W        = 4
) (
  input logic                  clk_in,
  input logic                  reset_in,
  ld_str_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] WORD_LIM = ADDR_W'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept;
  logic       commit;

  logic [ADDR_W-1:0] r_addr;
  logic              r_w_en;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic [TAG_W-1:0]  r_tag;
  logic [RD_W-1:0]   r_rd;

  logic [31:0]       rsp_rdata;
  logic [TAG_W-1:0]  rsp_tag;
  logic [RD_W-1:0]   rsp_rd;
  logic              rsp_st;
  logic              rsp_err;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the commit happens on the acceptance edge, so the
  // operation is taken straight from the bus instead of the capture registers.
  logic              use_bus;
  logic [ADDR_W-1:0] c_addr;
  logic              c_w_en;
  logic [1:0]        c_size;
  logic              c_signed;
  logic [31:0]       c_wdata;
  logic [TAG_W-1:0]  c_tag;
  logic [RD_W-1:0]   c_rd;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic [31:0]       c_word;
  logic [31:0]       b_shift;
  logic [7:0]        b_val;
  logic [15:0]       h_val;
  logic [31:0]       ld_val;
  logic [3:0]        be;
  logic [31:0]       w_word;

  assign bus.req_ready     = (state == ST_IDLE);
  assign bus.resp_valid    = (state == ST_RESP);
  assign bus.resp_rdata    = rsp_rdata;
  assign bus.resp_tag      = rsp_tag;
  assign bus.resp_rd_addr  = rsp_rd;
  assign bus.resp_is_store = rsp_st;
  assign bus.resp_err      = rsp_err;

  assign accept  = bus.req_valid && (state == ST_IDLE);
  assign use_bus = (state == ST_IDLE);

  always_comb begin
    c_addr   = use_bus ? bus.req_addr    : r_addr;
    c_w_en   = use_bus ? bus.req_w_en    : r_w_en;
    c_size   = use_bus ? bus.req_size    : r_size;
    c_signed = use_bus ? bus.req_signed  : r_signed;
    c_wdata  = use_bus ? bus.req_wdata   : r_wdata;
    c_tag    = use_bus ? bus.req_tag     : r_tag;
    c_rd     = use_bus ? bus.req_rd_addr : r_rd;
  end

  always_comb begin
    c_err = (c_size == 2'b11)
          | ((c_size == 2'b01) & c_addr[0])
          | ((c_size == 2'b10) & (|c_addr[1:0]))
          | ((c_addr >> 2) >= WORD_LIM);
    c_idx   = c_addr[IDX_W+1:2];
    c_word  = mem[c_idx];
    b_shift = c_word >> {c_addr[1:0], 3'b000};
    b_val   = b_shift[7:0];
    h_val   = c_addr[1] ? c_word[31:16] : c_word[15:0];
  end

  always_comb begin
    ld_val = '0;
    be     = '0;
    w_word = '0;
    case (c_size)
      2'b00: begin
        ld_val          = {{24{c_signed & b_val[7]}}, b_val};
        be[c_addr[1:0]] = 1'b1;
        w_word          = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        ld_val = {{16{c_signed & h_val[15]}}, h_val};
        be     = c_addr[1] ? 4'b1100 : 4'b0011;
        w_word = {2{c_wdata[15:0]}};
      end
      2'b10: begin
        ld_val = c_word;
        be     = '1;
        w_word = c_wdata;
      end
      default: begin
        ld_val = '0;
        be     = '0;
        w_word = '0;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = ST_RESP;
            commit   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx = ST_RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      r_addr    <= '0;
      r_w_en    <= 1'b0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      r_wdata   <= '0;
      r_tag     <= '0;
      r_rd      <= '0;
      rsp_rdata <= '0;
      rsp_tag   <= '0;
      rsp_rd    <= '0;
      rsp_st    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        r_addr   <= bus.req_addr;
        r_w_en   <= bus.req_w_en;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_wdata  <= bus.req_wdata;
        r_tag    <= bus.req_tag;
        r_rd     <= bus.req_rd_addr;
      end
      if (commit) begin
        rsp_rdata <= (c_w_en || c_err) ? '0 : ld_val;
        rsp_tag   <= c_tag;
        rsp_rd    <= c_rd;
        rsp_st    <= c_w_en;
        rsp_err   <= c_err;
      end
    end
  end

  // RAM is never reset; the write is gated by reset so an abandoned request cannot land.
  always_ff @(posedge clk_in) begin
    if (reset_in && commit && c_w_en && !c_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[c_idx][8*i +: 8] <= w_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ld_str_mem_responder.sv
// Directed bench for ld_str_mem_responder: one instance with 1 wait state,
// one with 3 wait states for the reset-during-wait scenario.
module tb_ld_str_mem_responder;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  ld_str_mem_responder_if #(.ADDR_W(32), .TAG_W(4), .RD_W(4)) ia ();
  ld_str_mem_responder_if #(.ADDR_W(32), .TAG_W(4), .RD_W(4)) ib ();

  ld_str_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(1), .TAG_W(4), .RD_W(4))
    dut_a (.clk_in(clk), .reset_in(rst_a), .bus(ia));
  ld_str_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(3), .TAG_W(4), .RD_W(4))
    dut_b (.clk_in(clk), .reset_in(rst_b), .bus(ib));

  int n_checks = 0;
  int n_fail   = 0;

  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err, got_st;
  logic [3:0]  got_tag, got_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit sel, input bit v, input bit w, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] tg, input logic [3:0] rd);
    if (!sel) begin
      ia.req_valid = v; ia.req_w_en = w; ia.req_size = sz; ia.req_signed = sg;
      ia.req_addr = a; ia.req_wdata = wd; ia.req_tag = tg; ia.req_rd_addr = rd;
    end else begin
      ib.req_valid = v; ib.req_w_en = w; ib.req_size = sz; ib.req_signed = sg;
      ib.req_addr = a; ib.req_wdata = wd; ib.req_tag = tg; ib.req_rd_addr = rd;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ib.req_ready : ia.req_ready;
  endfunction

  function automatic logic rvalid(input bit sel);
    return sel ? ib.resp_valid : ia.resp_valid;
  endfunction

  task automatic sample_resp(input bit sel);
    got_rdata = sel ? ib.resp_rdata    : ia.resp_rdata;
    got_err   = sel ? ib.resp_err      : ia.resp_err;
    got_st    = sel ? ib.resp_is_store : ia.resp_is_store;
    got_tag   = sel ? ib.resp_tag      : ia.resp_tag;
    got_rd    = sel ? ib.resp_rd_addr  : ia.resp_rd_addr;
  endtask

  // Waits (bounded) for resp_valid after an acceptance edge; latency counts edges.
  task automatic wait_resp(input bit sel);
    got_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rvalid(sel)) begin
        got_lat = k;
        break;
      end
    end
    sample_resp(sel);
  endtask

  task automatic run_txn(input bit sel, input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] tg, input logic [3:0] rd);
    @(negedge clk);
    set_req(sel, 1'b1, w, sz, sg, a, wd, tg, rd);
    for (int k = 0; k < 40 && !rdy(sel); k++) @(negedge clk);
    @(posedge clk);
    #1 set_req(sel, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    wait_resp(sel);
    @(posedge clk);
  endtask

  task automatic expect_resp(input string nm, input int lat, input logic [31:0] rdata,
                             input logic err, input logic st);
    check({nm, ".lat"},   32'(got_lat), 32'(lat));
    check({nm, ".rdata"}, got_rdata, rdata);
    check({nm, ".err"},   {31'd0, got_err}, {31'd0, err});
    check({nm, ".store"}, {31'd0, got_st}, {31'd0, st});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ia.resp_ready = 1'b1;
    ib.resp_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    #23;
    check("rst.req_ready", {31'd0, ia.req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, ia.resp_valid}, 32'd0);
    sample_resp(1'b0);
    check("rst.fields", {got_rdata[15:0], 4'd0, got_tag, got_rd, 2'd0, got_st, got_err},
          32'd0);
    check("rst.rdata", got_rdata, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4'h1, 4'h0);
    expect_resp("st_word", 2, 32'h0, 1'b0, 1'b1);
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'h2, 4'h3);
    expect_resp("ld_word", 2, 32'hDEADBEEF, 1'b0, 1'b0);

    run_txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 4'h3, 4'h0);
    expect_resp("st_byte", 2, 32'h0, 1'b0, 1'b1);
    run_txn(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4'h4, 4'h1);
    check("ld_byte_s", got_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 4'h4, 4'h1);
    check("ld_byte_u", got_rdata, 32'h00000080);
    run_txn(1'b0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 4'h5, 4'h1);
    check("ld_word_merged", got_rdata, 32'h80ADBEEF);
    run_txn(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 4'h5, 4'h1);
    check("ld_half_hi_s", got_rdata, 32'hFFFF80AD);
    run_txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 4'h5, 4'h1);
    check("ld_half_lo_u", got_rdata, 32'h0000BEEF);

    run_txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 4'h6, 4'h1);
    expect_resp("half_misalign", 2, 32'h0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 4'h6, 4'h1);
    expect_resp("word_misalign", 2, 32'h0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, 4'h6, 4'h1);
    expect_resp("st_misalign", 2, 32'h0, 1'b1, 1'b1);
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'h6, 4'h1);
    check("word_unchanged", got_rdata, 32'h80ADBEEF);
    run_txn(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 4'h6, 4'h1);
    expect_resp("size_illegal", 2, 32'h0, 1'b1, 1'b0);
    run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 4'hA, 4'h5);
    expect_resp("out_of_range", 2, 32'h0, 1'b1, 1'b0);
    check("echo.tag", {28'd0, got_tag}, 32'hA);
    check("echo.rd", {28'd0, got_rd}, 32'h5);

    // Back-pressure: response held, second request waits for the handshake.
    @(negedge clk);
    ia.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'h3, 4'h7);
    @(posedge clk);
    #1 set_req(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 4'hC, 4'h2);
    wait_resp(1'b0);
    check("hold.lat", 32'(got_lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      sample_resp(1'b0);
      check("hold.rdata", got_rdata, 32'h80ADBEEF);
      check("hold.ctl", {24'd0, ia.resp_valid, ia.req_ready, got_err, got_st, got_tag},
            {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3});
      check("hold.rd", {28'd0, got_rd}, 32'h7);
    end
    ia.resp_ready = 1'b1;
    @(negedge clk);
    check("after_hs.ctl", {30'd0, ia.resp_valid, ia.req_ready}, {30'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1 set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    wait_resp(1'b0);
    expect_resp("second", 2, 32'h00000080, 1'b0, 1'b0);
    check("second.tag", {28'd0, got_tag}, 32'hC);
    @(posedge clk);

    // Three wait states: completed store, then a store abandoned by reset.
    run_txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 4'h8, 4'h0);
    expect_resp("b.st", 4, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 4'h9, 4'h6);
    @(posedge clk);
    #1 set_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check("b.wait.ready", {31'd0, ib.req_ready}, 32'd0);
    #2 rst_b = 1'b0;
    #1;
    sample_resp(1'b1);
    check("b.rst.ctl", {22'd0, ib.req_ready, ib.resp_valid, got_err, got_st, got_tag, got_rd},
          {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
    check("b.rst.rdata", got_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 4'hB, 4'h4);
    expect_resp("b.ld_old", 4, 32'h11223344, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
